// File: rtl/regsel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regsel_pkg
// Description : Shared state encoding and source-select constants for the
//               multi-source register select decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package regsel_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } regselState_e;

    // Source select: 0 picks the microsequencer, SRC_OP + k picks operand field k
    localparam int SRC_USEQ = 0;
    localparam int SRC_OP   = 1;

endpackage
`default_nettype wire

// File: rtl/regsel_prienc.sv
`default_nettype none
// ============================================================================
// Module      : regsel_prienc
// Description : First-set-bit finder; dir=0 returns the lowest set bit,
//               dir=1 the highest. valid is low for an empty mask.
// Revision    : 1.0 - initial release
// ============================================================================
module regsel_prienc
    import regsel_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] mask,
    input  logic         dir,
    output logic [W-1:0] idx,
    output logic         valid
);

    // The last match in loop order wins, so each loop scans toward the wanted end
    always_comb begin
        idx   = '0;
        valid = |mask;
        if (dir) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (mask[i]) idx = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regsel_multi.sv
`default_nettype none
// ============================================================================
// Module      : regsel_multi
// Description : Registered one-hot OE/load register select with a
//               register-list walker. Optional macro REGSEL_CONFLICT_EN
//               enables the registered OE/load collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regsel_multi
    import regsel_pkg::*;
#(
    parameter  int NREGS = 8,
    parameter  int NOPS  = 3,
    localparam int SELW  = $clog2(NREGS),
    localparam int SRCW  = $clog2(NOPS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 oe,
    input  logic                 load,
    input  logic [SRCW-1:0]      oe_src_sel,
    input  logic [SRCW-1:0]      load_src_sel,
    input  logic [SELW-1:0]      useq_sel_oe,
    input  logic [SELW-1:0]      useq_sel_load,
    input  logic [NOPS*SELW-1:0] ops,
    input  logic                 list_start,
    input  logic [NREGS-1:0]     list_mask,
    input  logic                 list_dir,
    input  logic                 list_is_load,
    input  logic                 step_en,
    input  logic                 list_abort,
    output logic [NREGS-1:0]     reg_oes,
    output logic [NREGS-1:0]     reg_loads,
    output logic                 list_busy,
    output logic [SELW-1:0]      list_idx,
    output logic                 list_done,
    output logic                 conflict
);

    // Indices at or beyond NREGS match no bit and yield an all-zero vector
    function automatic logic [NREGS-1:0] toOnehot(input logic [SELW-1:0] idx);
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (idx == SELW'(i));
        end
        return v;
    endfunction

    // Source values above NOPS match nothing and leave the vector at zero
    function automatic logic [NREGS-1:0] decodeVec(
        input logic                 en,
        input logic [SRCW-1:0]      src,
        input logic [SELW-1:0]      useqIdx,
        input logic [NOPS*SELW-1:0] fields
    );
        logic [NREGS-1:0] v;
        v = '0;
        if (en) begin
            if (src == SRCW'(SRC_USEQ)) v = toOnehot(useqIdx);
            for (int k = 0; k < NOPS; k++) begin
                if (src == SRCW'(SRC_OP + k)) v = toOnehot(fields[k*SELW +: SELW]);
            end
        end
        return v;
    endfunction

    regselState_e     r_state;
    regselState_e     w_stateNext;
    logic [NREGS-1:0] r_walkMask;
    logic [NREGS-1:0] w_walkMaskNext;
    logic             r_walkDir;
    logic             w_walkDirNext;
    logic             r_walkIsLoad;
    logic             w_walkIsLoadNext;
    logic [SELW-1:0]  r_walkIdx;
    logic [SELW-1:0]  w_walkIdxNext;
    logic             r_done;
    logic             w_doneNext;
    logic [NREGS-1:0] r_oes;
    logic [NREGS-1:0] r_loads;
    logic [NREGS-1:0] w_nextOes;
    logic [NREGS-1:0] w_nextLoads;

    logic [NREGS-1:0] w_remainMask;
    logic [SELW-1:0]  w_startIdx;
    logic             w_startValid;
    logic [SELW-1:0]  w_stepIdx;
    logic             w_stepValid;

    assign w_remainMask = r_walkMask & ~toOnehot(r_walkIdx);

    regsel_prienc #(
        .N (NREGS),
        .W (SELW)
    ) u_startEnc (
        .mask  (list_mask),
        .dir   (list_dir),
        .idx   (w_startIdx),
        .valid (w_startValid)
    );

    regsel_prienc #(
        .N (NREGS),
        .W (SELW)
    ) u_stepEnc (
        .mask  (w_remainMask),
        .dir   (r_walkDir),
        .idx   (w_stepIdx),
        .valid (w_stepValid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_walkMask   <= '0;
            r_walkDir    <= 1'b0;
            r_walkIsLoad <= 1'b0;
            r_walkIdx    <= '0;
            r_done       <= 1'b0;
            r_oes        <= '0;
            r_loads      <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_walkMask   <= w_walkMaskNext;
            r_walkDir    <= w_walkDirNext;
            r_walkIsLoad <= w_walkIsLoadNext;
            r_walkIdx    <= w_walkIdxNext;
            r_done       <= w_doneNext;
            r_oes        <= w_nextOes;
            r_loads      <= w_nextLoads;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_walkMaskNext   = r_walkMask;
        w_walkDirNext    = r_walkDir;
        w_walkIsLoadNext = r_walkIsLoad;
        w_walkIdxNext    = r_walkIdx;
        w_doneNext       = 1'b0;

        case (r_state)
            IDLE: begin
                w_walkIdxNext = '0;
                if (list_start && !list_abort) begin
                    if (w_startValid) begin
                        w_stateNext      = WALK;
                        w_walkMaskNext   = list_mask;
                        w_walkDirNext    = list_dir;
                        w_walkIsLoadNext = list_is_load;
                        w_walkIdxNext    = w_startIdx;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            WALK: begin
                if (list_abort) begin
                    w_stateNext    = IDLE;
                    w_walkMaskNext = '0;
                    w_walkIdxNext  = '0;
                end else if (step_en) begin
                    if (w_stepValid) begin
                        w_walkMaskNext = w_remainMask;
                        w_walkIdxNext  = w_stepIdx;
                    end else begin
                        w_stateNext    = IDLE;
                        w_walkMaskNext = '0;
                        w_walkIdxNext  = '0;
                        w_doneNext     = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext    = IDLE;
                w_walkMaskNext = '0;
                w_walkIdxNext  = '0;
            end
        endcase

        // Outputs are registered from next-state so they line up with list_idx
        w_nextOes   = decodeVec(oe, oe_src_sel, useq_sel_oe, ops);
        w_nextLoads = decodeVec(load, load_src_sel, useq_sel_load, ops);
        if (w_stateNext == WALK) begin
            if (w_walkIsLoadNext) w_nextLoads = toOnehot(w_walkIdxNext);
            else                  w_nextOes   = toOnehot(w_walkIdxNext);
        end
    end

    assign reg_oes   = r_oes;
    assign reg_loads = r_loads;
    assign list_busy = (r_state == WALK);
    assign list_idx  = r_walkIdx;
    assign list_done = r_done;

`ifdef REGSEL_CONFLICT_EN
    logic r_conflict;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_conflict <= 1'b0;
        else          r_conflict <= |(w_nextOes & w_nextLoads);
    end

    assign conflict = r_conflict;
`else
    assign conflict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regsel_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_regsel_multi
// Description : Scoreboard bench for regsel_multi (NREGS=8, NOPS=3) driven by
//               directed and random stimulus against a list-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regsel_multi;

    localparam int NREGS = 8;
    localparam int NOPS  = 3;

    typedef struct packed {
        logic [7:0] oes;
        logic [7:0] loads;
        logic       busy;
        logic [2:0] idx;
        logic       done;
        logic       conflict;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       oe = 1'b0;
    logic       load = 1'b0;
    logic [1:0] oe_src_sel = '0;
    logic [1:0] load_src_sel = '0;
    logic [2:0] useq_sel_oe = '0;
    logic [2:0] useq_sel_load = '0;
    logic [8:0] ops = '0;
    logic       list_start = 1'b0;
    logic [7:0] list_mask = '0;
    logic       list_dir = 1'b0;
    logic       list_is_load = 1'b0;
    logic       step_en = 1'b0;
    logic       list_abort = 1'b0;
    logic [7:0] reg_oes;
    logic [7:0] reg_loads;
    logic       list_busy;
    logic [2:0] list_idx;
    logic       list_done;
    logic       conflict;

    int    checks = 0;
    int    passes = 0;
    string phase = "reset";
    exp_t  expQ[$];

    // Reference model state: the walk is the ordered list of registers still to visit
    bit    mBusy = 1'b0;
    bit    mIsLoad = 1'b0;
    int    walkQ[$];

    regsel_multi #(
        .NREGS (NREGS),
        .NOPS  (NOPS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .oe            (oe),
        .load          (load),
        .oe_src_sel    (oe_src_sel),
        .load_src_sel  (load_src_sel),
        .useq_sel_oe   (useq_sel_oe),
        .useq_sel_load (useq_sel_load),
        .ops           (ops),
        .list_start    (list_start),
        .list_mask     (list_mask),
        .list_dir      (list_dir),
        .list_is_load  (list_is_load),
        .step_en       (step_en),
        .list_abort    (list_abort),
        .reg_oes       (reg_oes),
        .reg_loads     (reg_loads),
        .list_busy     (list_busy),
        .list_idx      (list_idx),
        .list_done     (list_done),
        .conflict      (conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] decodeModel(input bit en, input int src, input int useq);
        int r;
        if (!en) return 8'h00;
        if (src == 0)         r = useq;
        else if (src <= NOPS) r = int'((ops >> (3 * (src - 1))) & 9'h007);
        else                  return 8'h00;
        if (r >= NREGS) return 8'h00;
        return 8'h01 << r;
    endfunction

    task automatic modelStep(output exp_t e);
        bit doneNow;
        doneNow = 1'b0;
        if (mBusy) begin
            if (list_abort) begin
                mBusy = 1'b0;
                walkQ.delete();
            end else if (step_en) begin
                void'(walkQ.pop_front());
                if (walkQ.size() == 0) begin
                    mBusy   = 1'b0;
                    doneNow = 1'b1;
                end
            end
        end else if (list_start && !list_abort) begin
            if (list_mask == 8'h00) begin
                doneNow = 1'b1;
            end else begin
                mBusy   = 1'b1;
                mIsLoad = list_is_load;
                walkQ.delete();
                if (!list_dir) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (list_mask[i]) walkQ.push_back(i);
                    end
                end else begin
                    for (int i = NREGS - 1; i >= 0; i--) begin
                        if (list_mask[i]) walkQ.push_back(i);
                    end
                end
            end
        end
        e.oes   = decodeModel(oe, int'(oe_src_sel), int'(useq_sel_oe));
        e.loads = decodeModel(load, int'(load_src_sel), int'(useq_sel_load));
        e.busy  = mBusy;
        e.idx   = mBusy ? 3'(walkQ[0]) : 3'd0;
        if (mBusy) begin
            if (mIsLoad) e.loads = 8'h01 << walkQ[0];
            else         e.oes   = 8'h01 << walkQ[0];
        end
        e.done = doneNow;
`ifdef REGSEL_CONFLICT_EN
        e.conflict = |(e.oes & e.loads);
`else
        e.conflict = 1'b0;
`endif
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic tick();
        exp_t e;
        modelStep(e);
        expQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic setIdle();
        oe = 1'b0; load = 1'b0; list_start = 1'b0; step_en = 1'b0; list_abort = 1'b0;
    endtask

    task automatic checkZero(input string name);
        checks++;
        if (reg_oes !== 8'h00 || reg_loads !== 8'h00 || list_busy !== 1'b0 ||
            list_idx !== 3'd0 || list_done !== 1'b0 || conflict !== 1'b0) begin
            $display("FAIL %s: got oes=%h loads=%h busy=%b idx=%0d done=%b conf=%b, required all zero",
                     name, reg_oes, reg_loads, list_busy, list_idx, list_done, conflict);
        end else begin
            passes++;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #1;
        if (reset_n && expQ.size() > 0) begin
            e = expQ.pop_front();
            got.oes = reg_oes; got.loads = reg_loads; got.busy = list_busy;
            got.idx = list_idx; got.done = list_done; got.conflict = conflict;
            checks++;
            if (got !== e) begin
                $display("FAIL %s: got oes=%h loads=%h busy=%b idx=%0d done=%b conf=%b, expected oes=%h loads=%h busy=%b idx=%0d done=%b conf=%b",
                         phase, got.oes, got.loads, got.busy, got.idx, got.done, got.conflict,
                         e.oes, e.loads, e.busy, e.idx, e.done, e.conflict);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        setIdle();
        #3;
        checkZero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        phase = "oe_source_decode";
        oe = 1'b1; ops = {3'd7, 3'd3, 3'd1}; useq_sel_oe = 3'd2;
        for (int s = 0; s < 4; s++) begin
            oe_src_sel = 2'(s);
            tick();
            tick();
        end
        setIdle();
        tick();

        phase = "walk_ascending_load";
        list_mask = 8'h29; list_dir = 1'b0; list_is_load = 1'b1; list_start = 1'b1;
        tick();
        list_start = 1'b0; step_en = 1'b1;
        repeat (3) tick();
        step_en = 1'b0;
        repeat (2) tick();

        phase = "walk_descending_toggle";
        list_mask = 8'h29; list_dir = 1'b1; list_is_load = 1'b0; list_start = 1'b1;
        oe = 1'b1; oe_src_sel = 2'd1; load = 1'b1; load_src_sel = 2'd2;
        tick();
        list_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step_en = i[0];
            list_start = (i == 2);
            list_mask = 8'h81;
            tick();
        end
        setIdle();
        tick();

        phase = "empty_mask_start";
        list_mask = 8'h00; list_start = 1'b1;
        tick();
        list_start = 1'b0;
        tick();

        phase = "abort_mid_walk";
        list_mask = 8'h29; list_dir = 1'b0; list_is_load = 1'b1; list_start = 1'b1;
        tick();
        list_start = 1'b0; step_en = 1'b1;
        tick();
        list_abort = 1'b1; list_start = 1'b1;
        tick();
        setIdle();
        repeat (2) tick();

        phase = "reset_mid_walk";
        list_mask = 8'hF0; list_dir = 1'b0; list_is_load = 1'b0; list_start = 1'b1;
        tick();
        list_start = 1'b0; step_en = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkZero("async_reset_mid_walk");
        @(negedge clk);
        checkZero("reset_held");
        setIdle();
        mBusy = 1'b0;
        walkQ.delete();
        reset_n = 1'b1;
        phase = "walk_after_reset";
        list_mask = 8'h06; list_dir = 1'b1; list_is_load = 1'b1; list_start = 1'b1;
        tick();
        list_start = 1'b0; step_en = 1'b1;
        repeat (3) tick();
        setIdle();

        phase = "same_register_oe_load";
        oe = 1'b1; load = 1'b1; oe_src_sel = 2'd0; load_src_sel = 2'd0;
        useq_sel_oe = 3'd4; useq_sel_load = 3'd4;
        repeat (2) tick();
        setIdle();
        tick();

        phase = "random";
        for (int n = 0; n < 500; n++) begin
            oe            = 1'($urandom_range(0, 1));
            load          = 1'($urandom_range(0, 1));
            oe_src_sel    = 2'($urandom_range(0, 3));
            load_src_sel  = 2'($urandom_range(0, 3));
            useq_sel_oe   = 3'($urandom_range(0, 7));
            useq_sel_load = 3'($urandom_range(0, 7));
            ops           = 9'($urandom);
            list_start    = ($urandom_range(0, 5) == 0);
            list_mask     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            list_dir      = 1'($urandom_range(0, 1));
            list_is_load  = 1'($urandom_range(0, 1));
            step_en       = 1'($urandom_range(0, 1));
            list_abort    = ($urandom_range(0, 15) == 0);
            tick();
        end
        setIdle();
        tick();

        checks++;
        if (expQ.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", expQ.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
